// File: rtl/irq_pkg.sv
// Shared types and register map for the external interrupt arbiter.
package irq_pkg;

    typedef enum logic [1:0] {IRQ_IDLE, IRQ_ARMED, IRQ_SERVICE} irq_state;

    localparam logic [1:0] CFG_ENABLE  = 2'd0;
    localparam logic [1:0] CFG_EDGE    = 2'd1;
    localparam logic [1:0] CFG_PENDING = 2'd2;
    localparam logic [1:0] CFG_INSVC   = 2'd3;

    localparam logic [3:0] VEC_NONE = 4'h0;

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: input synchronizer, edge detect and pending bit
// with claim / write-1-to-clear in edge mode.
module irq_gateway #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic irq,
    input  logic edge_mode,
    input  logic claim_clr,
    input  logic w1c_clr,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   synced_d;

    assign synced = sync_q[SYNC_STAGES-1];

    // In edge mode a new rising edge wins over a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q   <= '0;
            synced_d <= 1'b0;
            pending  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], irq};
            synced_d <= synced;
            if (edge_mode) begin
                if (synced && !synced_d)
                    pending <= 1'b1;
                else if (claim_clr || w1c_clr)
                    pending <= 1'b0;
            end else begin
                pending <= synced;
            end
        end
    end

endmodule

// File: rtl/ext_irq_arbiter.sv
// External interrupt arbiter: fixed-priority selection of N_SRC gated
// sources into one meip request with a claim/complete service handshake.
module ext_irq_arbiter
    import irq_pkg::*;
#(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_SRC-1:0] i_irq,
    input  logic             i_cfg_we,
    input  logic [1:0]       i_cfg_addr,
    input  logic [N_SRC-1:0] i_cfg_wdata,
    output logic [N_SRC-1:0] o_cfg_rdata,
    input  logic             i_claim,
    input  logic             i_complete,
    output logic             o_meip,
    output logic [3:0]       o_vecto_no,
    output logic             o_busy
);

    if (N_SRC < 1 || N_SRC > 15) begin : g_bad_n_src
        $error("ext_irq_arbiter: N_SRC must be in 1..15 for 4-bit vectors");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("ext_irq_arbiter: SYNC_STAGES must be at least 2");
    end

    irq_state         state;
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] edge_mode;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] eligible;
    logic [3:0]       in_service_id;
    logic [3:0]       winner;
    logic             claim_take;
    logic             w1c_we;

    assign claim_take = (state == IRQ_ARMED) && i_claim;
    assign w1c_we     = i_cfg_we && (i_cfg_addr == CFG_PENDING);

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        irq_gateway #(.SYNC_STAGES(SYNC_STAGES)) u_gateway (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .irq       (i_irq[i]),
            .edge_mode (edge_mode[i]),
            .claim_clr (claim_take && (o_vecto_no == 4'(i + 1))),
            .w1c_clr   (w1c_we && i_cfg_wdata[i]),
            .pending   (pending[i])
        );
    end

    assign eligible = pending & enable;

    // Source 0 has the highest priority.
    always_comb begin
        winner = VEC_NONE;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i])
                winner = 4'(i + 1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            enable    <= '0;
            edge_mode <= '0;
        end else if (i_cfg_we) begin
            if (i_cfg_addr == CFG_ENABLE)
                enable <= i_cfg_wdata;
            if (i_cfg_addr == CFG_EDGE)
                edge_mode <= i_cfg_wdata;
        end
    end

    always_comb begin
        o_cfg_rdata = '0;
        case (i_cfg_addr)
            CFG_ENABLE:  o_cfg_rdata = enable;
            CFG_EDGE:    o_cfg_rdata = edge_mode;
            CFG_PENDING: o_cfg_rdata = pending;
            CFG_INSVC:   o_cfg_rdata = N_SRC'(in_service_id);
            default:     o_cfg_rdata = '0;
        endcase
    end

    // A claim in ARMED takes precedence over eligibility dropping that cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IRQ_IDLE;
            o_meip        <= 1'b0;
            o_vecto_no    <= VEC_NONE;
            o_busy        <= 1'b0;
            in_service_id <= VEC_NONE;
        end else begin
            case (state)
                IRQ_IDLE: begin
                    if (eligible != '0) begin
                        state      <= IRQ_ARMED;
                        o_meip     <= 1'b1;
                        o_vecto_no <= winner;
                    end
                end
                IRQ_ARMED: begin
                    if (i_claim) begin
                        state         <= IRQ_SERVICE;
                        in_service_id <= o_vecto_no;
                        o_meip        <= 1'b0;
                        o_vecto_no    <= VEC_NONE;
                        o_busy        <= 1'b1;
                    end else if (eligible == '0) begin
                        state      <= IRQ_IDLE;
                        o_meip     <= 1'b0;
                        o_vecto_no <= VEC_NONE;
                    end else begin
                        o_vecto_no <= winner;
                    end
                end
                IRQ_SERVICE: begin
                    if (i_complete) begin
                        state         <= IRQ_IDLE;
                        o_busy        <= 1'b0;
                        in_service_id <= VEC_NONE;
                    end
                end
                default: begin
                    state      <= IRQ_IDLE;
                    o_meip     <= 1'b0;
                    o_vecto_no <= VEC_NONE;
                    o_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_irq_arbiter.sv
// Directed vector bench for ext_irq_arbiter with N_SRC=8, SYNC_STAGES=2.
module tb_ext_irq_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic       claim;
    logic       complete;
    logic       meip;
    logic [3:0] vecto_no;
    logic       busy;

    int n_vec = 0;
    int n_mis = 0;

    ext_irq_arbiter #(.N_SRC(8), .SYNC_STAGES(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_irq       (irq),
        .i_cfg_we    (cfg_we),
        .i_cfg_addr  (cfg_addr),
        .i_cfg_wdata (cfg_wdata),
        .o_cfg_rdata (cfg_rdata),
        .i_claim     (claim),
        .i_complete  (complete),
        .o_meip      (meip),
        .o_vecto_no  (vecto_no),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] irq;
        logic       claim;
        logic       cmpl;
        logic       meip;
        logic [3:0] vec;
        logic       busy;
        logic [7:0] rdata;
    } vec_t;

    vec_t tv[$];

    task automatic v(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                     input logic [7:0] irq_in, input logic clm, input logic cmp,
                     input logic e_meip, input logic [3:0] e_vec, input logic e_busy,
                     input logic [7:0] e_rdata);
        vec_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.irq = irq_in;
        t.claim = clm; t.cmpl = cmp;
        t.meip = e_meip; t.vec = e_vec; t.busy = e_busy; t.rdata = e_rdata;
        tv.push_back(t);
    endtask

    // Inputs change on the falling edge and are held for one rising edge.
    task automatic drive(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                         input logic [7:0] irq_in, input logic clm, input logic cmp);
        cfg_we = we; cfg_addr = addr; cfg_wdata = wdata;
        irq = irq_in; claim = clm; complete = cmp;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        irq = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        claim = 1'b0; complete = 1'b0;

        //  we addr wdata irq  clm cmp  meip vec busy rdata
        // level-mode source 0, claim / complete
        v(1, 0, 8'h01, 8'h00, 0, 0, 0, 0, 0, 8'h01);
        v(0, 0, 8'h00, 8'h01, 0, 0, 0, 0, 0, 8'h01);
        v(0, 0, 8'h00, 8'h01, 0, 0, 0, 0, 0, 8'h01);
        v(0, 2, 8'h00, 8'h01, 0, 0, 0, 0, 0, 8'h01);
        v(0, 2, 8'h00, 8'h01, 0, 0, 1, 1, 0, 8'h01);
        v(0, 3, 8'h00, 8'h01, 1, 0, 0, 0, 1, 8'h01);
        v(0, 3, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h01);
        v(0, 3, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h01);
        v(0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00);
        v(0, 3, 8'h00, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        v(0, 2, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00);
        // edge mode, simultaneous pulses on 5 and 2
        v(1, 1, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 8'hFF);
        v(1, 0, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 8'hFF);
        v(0, 2, 8'h00, 8'h24, 0, 0, 0, 0, 0, 8'h00);
        v(0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        v(0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h24);
        v(0, 2, 8'h00, 8'h00, 0, 0, 1, 3, 0, 8'h24);
        v(0, 2, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h20);
        v(0, 3, 8'h00, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        v(0, 2, 8'h00, 8'h00, 0, 0, 1, 6, 0, 8'h20);
        v(0, 3, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h06);
        v(0, 2, 8'h00, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        v(0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        // higher-priority arrival replaces vector while ARMED
        v(0, 2, 8'h00, 8'h40, 0, 0, 0, 0, 0, 8'h00);
        v(0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        v(0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h40);
        v(0, 2, 8'h00, 8'h00, 0, 0, 1, 7, 0, 8'h40);
        v(0, 2, 8'h00, 8'h02, 0, 0, 1, 7, 0, 8'h40);
        v(0, 2, 8'h00, 8'h00, 0, 0, 1, 7, 0, 8'h40);
        v(0, 2, 8'h00, 8'h00, 0, 0, 1, 7, 0, 8'h42);
        v(0, 2, 8'h00, 8'h00, 0, 0, 1, 2, 0, 8'h42);
        v(0, 2, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h40);
        v(0, 3, 8'h00, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        v(0, 2, 8'h00, 8'h00, 0, 0, 1, 7, 0, 8'h40);
        v(0, 3, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h07);
        v(0, 2, 8'h00, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        // disabled pending source 3, then enabled
        v(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        v(0, 2, 8'h00, 8'h08, 0, 0, 0, 0, 0, 8'h00);
        v(0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        v(0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h08);
        v(0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h08);
        v(1, 0, 8'h08, 8'h00, 0, 0, 0, 0, 0, 8'h08);
        v(0, 2, 8'h00, 8'h00, 0, 0, 1, 4, 0, 8'h08);
        v(0, 3, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h04);
        v(0, 2, 8'h00, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        // re-pend of source 0 while in service
        v(1, 0, 8'h01, 8'h00, 0, 0, 0, 0, 0, 8'h01);
        v(0, 2, 8'h00, 8'h01, 0, 0, 0, 0, 0, 8'h00);
        v(0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        v(0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h01);
        v(0, 2, 8'h00, 8'h00, 0, 0, 1, 1, 0, 8'h01);
        v(0, 2, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h00);
        v(0, 2, 8'h00, 8'h01, 0, 0, 0, 0, 1, 8'h00);
        v(0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00);
        v(0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h01);
        v(0, 2, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h01);
        v(0, 2, 8'h00, 8'h00, 0, 1, 0, 0, 0, 8'h01);
        v(0, 2, 8'h00, 8'h00, 0, 0, 1, 1, 0, 8'h01);
        v(0, 3, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h01);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_meip", int'(meip), 0);
        chk("reset_vec", int'(vecto_no), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;

        for (int k = 0; k < tv.size(); k++) begin
            drive(tv[k].we, tv[k].addr, tv[k].wdata, tv[k].irq, tv[k].claim, tv[k].cmpl);
            n_vec++;
            if (meip !== tv[k].meip || vecto_no !== tv[k].vec ||
                busy !== tv[k].busy || cfg_rdata !== tv[k].rdata) begin
                n_mis++;
                $display("FAIL vec%0d: got meip=%b vec=%0d busy=%b rdata=0x%02h, expected meip=%b vec=%0d busy=%b rdata=0x%02h",
                         k, meip, vecto_no, busy, cfg_rdata,
                         tv[k].meip, tv[k].vec, tv[k].busy, tv[k].rdata);
            end
        end

        // Asynchronous reset while source 0 is in service.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_meip", int'(meip), 0);
        chk("rst_vec", int'(vecto_no), 0);
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            #1;
            chk($sformatf("rst_reg%0d", a), int'(cfg_rdata), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 3, 8'h00, 8'h00, 0, 1);
        chk("stray_cmpl_busy", int'(busy), 0);
        chk("stray_cmpl_insvc", int'(cfg_rdata), 0);
        drive(0, 0, 8'h00, 8'h00, 0, 0);
        chk("stray_cmpl_meip", int'(meip), 0);

        // Pin-to-meip latency on the lowest-priority source, level mode.
        drive(1, 0, 8'h80, 8'h00, 0, 0);
        cfg_we = 1'b0; irq = 8'h80;
        cnt = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end while (!meip && cnt < 20);
        chk("latency_cycles", cnt, 4);
        chk("latency_vec", int'(vecto_no), 8);
        drive(0, 2, 8'h00, 8'h80, 1, 0);
        chk("level_claim_busy", int'(busy), 1);
        chk("level_claim_pend", int'(cfg_rdata), 8'h80);
        drive(1, 2, 8'h80, 8'h80, 0, 0);
        chk("level_w1c_ignored", int'(cfg_rdata), 8'h80);
        drive(1, 3, 8'h0F, 8'h00, 0, 0);
        chk("insvc_write_ignored", int'(cfg_rdata), 8);
        repeat (3) drive(0, 2, 8'h00, 8'h00, 0, 0);
        chk("level_pend_drop", int'(cfg_rdata), 0);
        drive(0, 3, 8'h00, 8'h00, 0, 1);
        drive(0, 0, 8'h00, 8'h00, 0, 0);
        chk("level_idle_meip", int'(meip), 0);

        // Edge-mode write-1-to-clear on a disabled source.
        drive(1, 1, 8'h08, 8'h00, 0, 0);
        drive(0, 2, 8'h00, 8'h08, 0, 0);
        drive(0, 2, 8'h00, 8'h00, 0, 0);
        drive(0, 2, 8'h00, 8'h00, 0, 0);
        chk("w1c_before", int'(cfg_rdata), 8'h08);
        drive(1, 2, 8'h08, 8'h00, 0, 0);
        chk("w1c_after", int'(cfg_rdata), 8'h00);
        chk("w1c_meip", int'(meip), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ext_irq_arbiter.md
Name: ext_irq_arbiter

Overview:
Arbitrates up to N_SRC external interrupt lines into the single external-interrupt request consumed by machine_controller. Drives o_meip and o_vecto_no (1..8, mapped by the controller to intr_cause 1000..1111). Runs a claim/complete handshake with the trap flow, so only one external interrupt is in service at a time. Exposes a small config/status register port for enable and edge/level mode.

Parameters:
N_SRC, 8, number of interrupt sources (1..15); source i maps to vector i+1.
SYNC_STAGES, 2, flop stages in the per-source input synchronizer (>=2).

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_irq  in  N_SRC  raw asynchronous interrupt lines, active-high
i_cfg_we  in  1  config write strobe
i_cfg_addr  in  2  register select: 0 ENABLE, 1 EDGE_MODE, 2 PENDING, 3 IN_SERVICE
i_cfg_wdata  in  N_SRC  write data
o_cfg_rdata  out  N_SRC  combinational read data for i_cfg_addr
i_claim  in  1  one-cycle pulse when the core takes the external-interrupt trap
i_complete  in  1  one-cycle pulse on mret of the external handler
o_meip  out  1  external interrupt pending to the core
o_vecto_no  out  4  winning vector; 0 = none
o_busy  out  1  high while an interrupt is in service

Behaviour:
- Reset (async, i_rst_n=0): all synchronizers, pending, ENABLE, EDGE_MODE and in_service_id clear to 0. FSM goes to IDLE. o_meip=0, o_vecto_no=0, o_busy=0.
- Reset mid-operation: same reset state. Any in-service interrupt is dropped with no complete required.
- Per-source gateway:
  - Synchronizer of SYNC_STAGES flops, then a registered pending bit.
  - Edge mode (EDGE_MODE[i]=1): pending set on a 0->1 transition of the synced line. Cleared on claim of source i, or by writing 1 to PENDING[i].
  - Level mode: pending <= synced level every cycle. Claim and PENDING writes have no effect.
  - Set beats clear when both occur in the same cycle.
- eligible = pending & ENABLE. Winner = lowest set index (source 0 has highest priority). Vector = index+1.
- FSM (registered; outputs registered):
  - IDLE: o_meip=0, o_vecto_no=0. If eligible!=0, go to ARMED; next-cycle o_meip=1 and o_vecto_no=winner.
  - ARMED: o_meip=1. o_vecto_no re-evaluated every cycle, so a higher-priority arrival replaces it before claim. If eligible==0, go to IDLE (o_meip=0, vecto_no=0). On i_claim: in_service_id <= current o_vecto_no, clear the edge pending bit of that source, go to SERVICE.
  - SERVICE: o_meip=0, o_vecto_no=0, o_busy=1. On i_complete: go to IDLE and clear in_service_id. New pendings accumulate but are not signalled; this includes a re-pend of the same source.
  - i_claim outside ARMED is ignored. i_complete outside SERVICE is ignored.
- Latency: pin rising edge to o_meip=1 is SYNC_STAGES+2 cycles when the source is enabled and the FSM is IDLE. i_complete to o_meip=1 is 2 cycles if eligible!=0 (SERVICE->IDLE->ARMED).
- Config:
  - ENABLE and EDGE_MODE are R/W and update at the write edge. Changes take effect on the next arbitration and do not abort SERVICE.
  - PENDING is read-only plus write-1-to-clear (edge mode only).
  - IN_SERVICE is read-only; it returns in_service_id zero-extended, and writes to it are ignored.
- Width rule: vectors are 4-bit. N_SRC>15 is illegal (elaboration assertion).

Decomposition:
- Package irq_pkg holds:
  - typedef enum logic [1:0] {IRQ_IDLE, IRQ_ARMED, IRQ_SERVICE} irq_state
  - localparams CFG_ENABLE=0, CFG_EDGE=1, CFG_PENDING=2, CFG_INSVC=3
  - VEC_NONE=4'h0
- One sub-module irq_gateway (synchronizer, edge detect, pending bit, w1c/claim clear), instantiated N_SRC times via generate. The priority encoder and FSM live in the top.

Test Plan:
1. ENABLE=0x01, level mode, i_irq[0] rises at cycle 0 -> o_meip=1, o_vecto_no=1 at cycle 4. i_claim -> o_meip=0, o_busy=1, IN_SERVICE reads 1. Drop irq, then i_complete -> IDLE, meip stays 0.
2. EDGE_MODE=0xFF, ENABLE=0xFF, pulse i_irq[5] and i_irq[2] in the same cycle -> o_vecto_no=3. Claim, then complete -> o_vecto_no=6 two cycles after complete.
3. Edge i_irq[6] raises vecto_no=7 in ARMED. Edge i_irq[1] before claim -> vecto_no switches to 2. Claim clears only PENDING[1], so PENDING reads 0x40.
4. ENABLE=0x00 with edge pending on source 3 -> o_meip stays 0 and PENDING reads 0x08. Write ENABLE=0x08 -> o_meip=1, vecto_no=4 one cycle after the write.
5. In SERVICE for source 0 (edge), pulse i_irq[0] again -> meip stays 0. After i_complete, meip=1 with vecto_no=1.
6. Assert i_rst_n=0 mid-SERVICE -> o_busy, o_meip, o_vecto_no and all registers read 0 immediately. Stray i_complete after reset is ignored.
